// File: rtl/aoc_node_pkg.sv
// Shared types for the node-string pipeline: packed node strings, the edge request
// carried from the line decoder, and the sequencer FSM encoding.
package aoc_node_pkg;

  localparam int unsigned NODE_STR_WIDTH = 15;

  typedef logic [NODE_STR_WIDTH-1:0] node_str_t;

  // One decoded edge; 'first' marks a source not yet seen in the stream
  typedef struct packed {
    logic      first;
    node_str_t src;
    node_str_t dst;
  } edge_req_t;

  // State names the pulse presented on the mapper outputs in the current cycle
  typedef enum logic [1:0] {
    StIdle,
    StIssueSrc,
    StIssueEdge,
    StDone
  } seq_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head. Simultaneous read and write are legal,
// including when full (the read frees the slot the write lands in).
module sync_fifo #(
  parameter int unsigned WIDTH = 31,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr, do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2)
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_wr && !do_rd) begin
        count_q <= count_q + (AW+1)'(1);
      end else if (do_rd && !do_wr) begin
        count_q <= count_q - (AW+1)'(1);
      end
    end
  end

  // Storage array; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/node_edge_sequencer.sv
// Buffers decoded edges and serialises them towards the node ID mapper: one
// src-registration pulse per line, then one pulse per edge, never both at once.
module node_edge_sequencer
  import aoc_node_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_first,
  input  node_str_t            in_src_str,
  input  node_str_t            in_dst_str,
  input  logic                 in_done,
  output logic                 src_node_str_valid,
  output logic                 edge_str_valid,
  output node_str_t            src_node_str,
  output node_str_t            dst_node_str,
  output logic                 decoding_done_str,
  output logic [CNT_WIDTH-1:0] line_cnt,
  output logic [CNT_WIDTH-1:0] edge_cnt,
  output logic                 overflow_err
);

  edge_req_t  push_req, head;
  logic       fifo_full, fifo_empty, pop;
  seq_state_e state_q, state_d;

  logic                 done_seen_q, done_seen_d;
  logic                 src_valid_q, src_valid_d;
  logic                 edge_valid_q, edge_valid_d;
  node_str_t            src_str_q, src_str_d;
  node_str_t            dst_str_q, dst_str_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
  logic [CNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;

  assign in_ready = !fifo_full && !reset;
  assign push_req = '{first: in_first, src: in_src_str, dst: in_dst_str};
  // The head leaves the FIFO in the cycle its edge pulse is decided
  assign pop      = (state_d == StIssueEdge);

  sync_fifo #(
    .WIDTH ($bits(edge_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (in_valid && in_ready),
    .wr_data (push_req),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      done_seen_q  <= 1'b0;
      src_valid_q  <= 1'b0;
      edge_valid_q <= 1'b0;
      src_str_q    <= '0;
      dst_str_q    <= '0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      line_cnt_q   <= '0;
      edge_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      done_seen_q  <= done_seen_d;
      src_valid_q  <= src_valid_d;
      edge_valid_q <= edge_valid_d;
      src_str_q    <= src_str_d;
      dst_str_q    <= dst_str_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      line_cnt_q   <= line_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
    end
  end

  // Next state: after a src pulse the same head is issued as an edge; otherwise the
  // head decides, and an empty FIFO with end-of-input seen retires into DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIssueSrc: state_d = StIssueEdge;
      StIdle, StIssueEdge: begin
        if (!fifo_empty) begin
          state_d = head.first ? StIssueSrc : StIssueEdge;
        end else if (done_seen_q) begin
          state_d = StDone;
        end else begin
          state_d = StIdle;
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Output values for the next cycle; strings hold between their pulses
  always_comb begin
    src_valid_d  = (state_d == StIssueSrc);
    edge_valid_d = (state_d == StIssueEdge);
    src_str_d    = src_valid_d  ? head.src : src_str_q;
    dst_str_d    = edge_valid_d ? head.dst : dst_str_q;
    done_d       = (state_d == StDone);
    done_seen_d  = done_seen_q || in_done;
    ovf_d        = ovf_q || (in_valid && done_seen_q);
    line_cnt_d   = (src_valid_d && line_cnt_q != '1) ? line_cnt_q + CNT_WIDTH'(1) : line_cnt_q;
    edge_cnt_d   = (edge_valid_d && edge_cnt_q != '1) ? edge_cnt_q + CNT_WIDTH'(1) : edge_cnt_q;
  end

  assign src_node_str_valid = src_valid_q;
  assign edge_str_valid     = edge_valid_q;
  assign src_node_str       = src_str_q;
  assign dst_node_str       = dst_str_q;
  assign decoding_done_str  = done_q;
  assign line_cnt           = line_cnt_q;
  assign edge_cnt           = edge_cnt_q;
  assign overflow_err       = ovf_q;

endmodule

// File: tb/tb_node_edge_sequencer.sv
// Scoreboard bench: a reference model turns each accepted edge into the mapper
// pulses it must produce and the cycle each one is due; a monitor pops and compares.
// A second instance with 2-bit counters sees the same stimulus to exercise saturation.
module tb_node_edge_sequencer;
  import aoc_node_pkg::*;

  localparam int DEPTH     = 16;
  localparam int SMALL_MAX = 3;

  logic      clk = 1'b0;
  logic      reset, in_valid, in_first, in_done;
  node_str_t in_src_str, in_dst_str;

  logic        in_ready, src_v, edge_v, done, ovf;
  node_str_t   src_s, dst_s;
  logic [15:0] line_cnt, edge_cnt;

  logic        in_ready_sm, src_v_sm, edge_v_sm, done_sm, ovf_sm;
  node_str_t   src_s_sm, dst_s_sm;
  logic [1:0]  line_cnt_sm, edge_cnt_sm;

  node_edge_sequencer #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
    .in_src_str(in_src_str), .in_dst_str(in_dst_str), .in_done(in_done),
    .src_node_str_valid(src_v), .edge_str_valid(edge_v), .src_node_str(src_s),
    .dst_node_str(dst_s), .decoding_done_str(done), .line_cnt(line_cnt), .edge_cnt(edge_cnt),
    .overflow_err(ovf)
  );

  node_edge_sequencer #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(2)) dut_sm (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_sm), .in_first(in_first),
    .in_src_str(in_src_str), .in_dst_str(in_dst_str), .in_done(in_done),
    .src_node_str_valid(src_v_sm), .edge_str_valid(edge_v_sm), .src_node_str(src_s_sm),
    .dst_node_str(dst_s_sm), .decoding_done_str(done_sm), .line_cnt(line_cnt_sm),
    .edge_cnt(edge_cnt_sm), .overflow_err(ovf_sm)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int sat(input int v);
    return (v > SMALL_MAX) ? SMALL_MAX : v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int        due;
    bit        is_src;
    node_str_t src;
    node_str_t dst;
    int        lcnt;
    int        ecnt;
  } pulse_t;

  pulse_t    exp_q[$];
  int        pop_due_q[$];
  int        acc = 0, popped = 0, last_due = -10;
  int        m_lines = 0, m_edges = 0;
  node_str_t m_src = '0;
  int        done_at = -1, exp_done_at = -1, ovf_at = -1;
  bit        exp_ready = 1'b0;

  // Each pulse is due two cycles after the push, or one cycle after the previous pulse
  always @(negedge clk) begin
    pulse_t p;
    int     t;
    while (pop_due_q.size() > 0 && pop_due_q[0] <= cyc) begin
      void'(pop_due_q.pop_front());
      popped++;
    end
    exp_ready = !reset && ((acc - popped) < DEPTH);
    if (reset) begin
      while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due > cyc) void'(exp_q.pop_back());
      pop_due_q.delete();
      acc = 0; popped = 0; last_due = cyc;
      m_lines = 0; m_edges = 0; m_src = '0;
      done_at = -1; exp_done_at = -1; ovf_at = -1;
    end else begin
      if (in_valid && done_at >= 0 && ovf_at < 0) ovf_at = cyc;
      if (in_valid && in_ready) begin
        acc++;
        if (done_at < 0) begin
          t = max2(cyc + 2, last_due + 1);
          if (in_first) begin
            m_lines++;
            m_src    = in_src_str;
            p.due    = t; p.is_src = 1'b1; p.src = m_src; p.dst = '0;
            p.lcnt   = m_lines; p.ecnt = m_edges;
            exp_q.push_back(p);
            t++;
          end
          m_edges++;
          p.due  = t; p.is_src = 1'b0; p.src = m_src; p.dst = in_dst_str;
          p.lcnt = m_lines; p.ecnt = m_edges;
          exp_q.push_back(p);
          pop_due_q.push_back(t);
          last_due = t;
        end
      end
      if (in_done && done_at < 0) begin
        done_at     = cyc;
        exp_done_at = max2(last_due + 1, cyc + 2);
      end
    end
  end

  // ---------------- monitor ----------------
  bit rst_prev = 1'b0;
  always @(negedge clk) begin
    pulse_t p;
    bit     es, ee;
    #1;
    es = 1'b0;
    ee = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      p  = exp_q.pop_front();
      es = p.is_src;
      ee = !p.is_src;
    end
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("in_ready_small", 32'(in_ready_sm), 32'(exp_ready));
    chk("exclusive", 32'(src_v && edge_v), 32'd0);
    chk("src_valid", 32'(src_v), 32'(es));
    chk("edge_valid", 32'(edge_v), 32'(ee));
    chk("edge_valid_small", 32'(edge_v_sm), 32'(ee));
    if (es) begin
      chk("src_str", 32'(src_s), 32'(p.src));
      chk("line_cnt", 32'(line_cnt), 32'(p.lcnt));
      chk("line_cnt_small", 32'(line_cnt_sm), 32'(sat(p.lcnt)));
    end
    if (ee) begin
      chk("edge_src_str", 32'(src_s), 32'(p.src));
      chk("dst_str", 32'(dst_s), 32'(p.dst));
      chk("edge_cnt", 32'(edge_cnt), 32'(p.ecnt));
      chk("edge_cnt_small", 32'(edge_cnt_sm), 32'(sat(p.ecnt)));
    end
    chk("done", 32'(done), 32'(exp_done_at >= 0 && cyc >= exp_done_at));
    chk("overflow", 32'(ovf), 32'(ovf_at >= 0 && cyc > ovf_at));
    if (rst_prev) begin
      chk("rst_src_str", 32'(src_s), 32'd0);
      chk("rst_dst_str", 32'(dst_s), 32'd0);
      chk("rst_line_cnt", 32'(line_cnt), 32'd0);
      chk("rst_edge_cnt", 32'(edge_cnt), 32'd0);
    end
    rst_prev = reset;
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input bit first, input node_str_t s, input node_str_t d, input bit dn);
    int waited = 0;
    in_valid = 1'b1; in_first = first; in_src_str = s; in_dst_str = d; in_done = dn;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        n_total++;
        n_bad++;
        $display("FAIL push_timeout got=in_ready_low want=accept_within_200");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_done = 1'b0;
  endtask

  task automatic wait_done();
    int waited = 0;
    while (!done && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    n_total++;
    if (!done) begin
      n_bad++;
      $display("FAIL done_timeout got=0 want=1");
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_done = 1'b0;
    in_src_str = '0; in_dst_str = '0;
    step(3);
    reset = 1'b0;
    step(2);

    // one two-edge line
    push(1'b1, 15'h0A1A, 15'h0003, 1'b0);
    push(1'b0, 15'h0A1A, 15'h0004, 1'b0);
    step(6);

    // two one-edge lines back to back
    push(1'b1, 15'h0001, 15'h0010, 1'b0);
    push(1'b1, 15'h0002, 15'h0011, 1'b0);
    step(6);

    // reset in the middle of a five-edge line, then a fresh line
    push(1'b1, 15'h0055, 15'h0100, 1'b0);
    for (int i = 1; i < 5; i++) push(1'b0, 15'h0055, node_str_t'(15'h0100 + i), 1'b0);
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(2);
    push(1'b1, 15'h0123, 15'h0007, 1'b0);
    push(1'b0, 15'h0123, 15'h0008, 1'b0);
    step(6);

    // a 20-edge line streamed continuously
    push(1'b1, 15'h0300, 15'h0000, 1'b0);
    for (int i = 1; i < 20; i++) push(1'b0, 15'h0300, node_str_t'(i), 1'b0);
    step(4);

    // one-edge lines arrive faster than they drain and fill the FIFO
    for (int i = 0; i < 48; i++) push(1'b1, node_str_t'(15'h1000 + i), node_str_t'(i), 1'b0);
    step(4);

    // random traffic with idle gaps
    for (int i = 0; i < 300; i++) begin
      push(($urandom_range(0, 2) == 0), node_str_t'($urandom), node_str_t'($urandom), 1'b0);
      if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
    end
    step(2);

    // end of input with the final push, then a late edge
    push(1'b1, 15'h7FFF, 15'h0005, 1'b0);
    push(1'b0, 15'h7FFF, 15'h0006, 1'b1);
    wait_done();
    step(3);
    push(1'b0, 15'h0001, 15'h0002, 1'b0);
    step(8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
